nbout_psum_ctrl: RTL and testbench

//  NBout-side partial-sum buffer and sequencer feeding the NFU-2 accumulate stage.

---
 rtl/nbout_psum_ctrl.sv | 155 +++++++++++++++
 tb/tb_nbout_psum_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbout_psum_ctrl.sv
// NBout partial-sum buffer and load/accumulate/write-back sequencer for NFU-2.
// Optional build macro NBOUT_FIRST_ZERO_EN adds i_first (zero load value for a first input tile).
module nbout_psum_ctrl #(
    parameter int BIT_WIDTH   = 16,
    parameter int Tn          = 16,
    parameter int G           = 4,
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int CNT_WIDTH   = 8,
    localparam int LANES      = (Tn / G) * G,
    localparam int VEC_W      = LANES * BIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_entry,
    input  logic [CNT_WIDTH-1:0]  i_num_accum,
`ifdef NBOUT_FIRST_ZERO_EN
    input  logic                  i_first,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic [VEC_W-1:0]      o_partial_sum,
    output logic                  o_load_partial_sum,
    output logic                  o_accum_en,
    input  logic [VEC_W-1:0]      i_nfu_output,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [VEC_W-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [VEC_W-1:0]      o_rd_data,
    output logic                  o_rd_valid,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   entry_q, entry_d;
    logic [VEC_W-1:0]        psum_q, psum_d;
    logic                    done_q, done_d;
    logic [VEC_W-1:0]        rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [VEC_W-1:0]        mem_q [NUM_ENTRIES];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [VEC_W-1:0]        mem_wdata;

    // Handshake: host requests and i_start are single-cycle strobes with no ready;
    // a host write/read is taken only in IDLE with i_start low, otherwise it is dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        entry_d    = entry_q;
        psum_d     = psum_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = entry_q;
        mem_wdata  = i_nfu_output;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    entry_d = i_entry;
                    cnt_d   = i_num_accum;
`ifdef NBOUT_FIRST_ZERO_EN
                    psum_d  = i_first ? '0 : mem_q[i_entry];
`else
                    psum_d  = mem_q[i_entry];
`endif
                    state_d = LOAD;
                end else begin
                    if (i_wr_en) begin
                        mem_we    = 1'b1;
                        mem_waddr = i_wr_addr;
                        mem_wdata = i_wr_data;
                    end
                    // Read uses the pre-write array, so a same-address write/read returns old data.
                    if (i_rd_en) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem_q[i_rd_addr];
                    end
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            entry_q    <= '0;
            psum_q     <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            entry_q    <= entry_d;
            psum_q     <= psum_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Buffer contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign o_busy             = (state_q != IDLE);
    assign o_done             = done_q;
    assign o_partial_sum      = psum_q;
    assign o_load_partial_sum = (state_q == LOAD);
    assign o_accum_en         = (state_q == ACCUM);
    assign o_rd_data          = rd_data_q;
    assign o_rd_valid         = rd_valid_q;
    assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Randomized bench for nbout_psum_ctrl: a behavioural NFU-2 (+1 per lane per accumulate
// cycle) drives i_nfu_output, and a buffer model predicts every job result and readout.
module tb_nbout_psum_ctrl;

    localparam int W     = 256;
    localparam int LANES = 16;
    localparam int BW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [2:0]    i_entry;
    logic [7:0]    i_num_accum;
`ifdef NBOUT_FIRST_ZERO_EN
    logic          i_first;
`endif
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_partial_sum;
    logic          o_load_partial_sum;
    logic          o_accum_en;
    logic [W-1:0]  i_nfu_output;
    logic          i_wr_en;
    logic [2:0]    i_wr_addr;
    logic [W-1:0]  i_wr_data;
    logic          i_rd_en;
    logic [2:0]    i_rd_addr;
    logic [W-1:0]  o_rd_data;
    logic          o_rd_valid;
    logic [1:0]    o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] model_mem [8];
    logic [W-1:0] nfu_acc = '0;

    nbout_psum_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_entry            (i_entry),
        .i_num_accum        (i_num_accum),
`ifdef NBOUT_FIRST_ZERO_EN
        .i_first            (i_first),
`endif
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_partial_sum      (o_partial_sum),
        .o_load_partial_sum (o_load_partial_sum),
        .o_accum_en         (o_accum_en),
        .i_nfu_output       (i_nfu_output),
        .i_wr_en            (i_wr_en),
        .i_wr_addr          (i_wr_addr),
        .i_wr_data          (i_wr_data),
        .i_rd_en            (i_rd_en),
        .i_rd_addr          (i_rd_addr),
        .o_rd_data          (o_rd_data),
        .o_rd_valid         (o_rd_valid),
        .o_dbg_state        (o_dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lane_add(input logic [W-1:0] v, input int k);
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*BW +: BW] = v[l*BW +: BW] + BW'(k);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural NFU-2: captures the loaded partial sum, adds 1 per lane per product cycle.
    always @(posedge clk) begin
        if (o_load_partial_sum) nfu_acc <= o_partial_sum;
        else if (o_accum_en)    nfu_acc <= lane_add(nfu_acc, 1);
    end
    assign i_nfu_output = nfu_acc;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [W-1:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = 3'(addr);
        i_wr_data = data;
        step();
        i_wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic host_read(input int addr);
        i_rd_en   = 1'b1;
        i_rd_addr = 3'(addr);
        step();
        i_rd_en = 1'b0;
        check_eq("rd_valid", W'(o_rd_valid), W'(1));
        check_eq("rd_data", o_rd_data, model_mem[addr]);
        step();
        check_eq("rd_valid_pulse", W'(o_rd_valid), W'(0));
        check_eq("rd_data_hold", o_rd_data, model_mem[addr]);
    endtask

    // Returns in the o_done cycle so a caller may start the next job back-to-back.
    task automatic run_job(input int entry, input int n, input bit first,
                           input bit disturb, input bit collide);
        logic [W-1:0] exp_load;
        int cyc, loads, accs, done_cyc;
        exp_load    = first ? '0 : model_mem[entry];
        i_start     = 1'b1;
        i_entry     = 3'(entry);
        i_num_accum = 8'(n);
`ifdef NBOUT_FIRST_ZERO_EN
        i_first     = first;
`endif
        if (collide) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 3'(entry);
            i_wr_data = ~model_mem[entry];
        end
        step();
        i_start = 1'b0;
        i_wr_en = 1'b0;
        cyc = 1; loads = 0; accs = 0; done_cyc = -1;
        while (cyc < n + 10) begin
            if (disturb) begin
                i_start = 1'b0;
                i_wr_en = 1'b0;
            end
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            if (o_load_partial_sum) begin
                loads++;
                check_eq("load_psum", o_partial_sum, exp_load);
            end
            if (o_accum_en) begin
                accs++;
                if (disturb && accs == 1) begin
                    i_start     = 1'b1;
                    i_entry     = 3'(entry ^ 1);
                    i_num_accum = 8'd0;
                    i_wr_en     = 1'b1;
                    i_wr_addr   = 3'(entry);
                    i_wr_data   = rand_vec();
                end
            end
            step();
            cyc++;
        end
        check_eq("load_cycles", W'(loads), W'(1));
        check_eq("accum_cycles", W'(accs), W'(n));
        check_eq("done_latency", W'(done_cyc), W'(n + 3));
        check_eq("busy_at_done", W'(o_busy), W'(0));
        check_eq("psum_hold", o_partial_sum, exp_load);
        if (done_cyc > 0) model_mem[entry] = lane_add(exp_load, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] newv;
        rst = 1'b1; i_start = 1'b0; i_entry = '0; i_num_accum = '0;
`ifdef NBOUT_FIRST_ZERO_EN
        i_first = 1'b0;
`endif
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_rd_en = 1'b0; i_rd_addr = '0;
        repeat (3) step();
        check_eq("rst_busy", W'(o_busy), W'(0));
        check_eq("rst_done", W'(o_done), W'(0));
        check_eq("rst_load", W'(o_load_partial_sum), W'(0));
        check_eq("rst_accum", W'(o_accum_en), W'(0));
        check_eq("rst_rd_valid", W'(o_rd_valid), W'(0));
        check_eq("rst_psum", o_partial_sum, '0);
        check_eq("rst_rd_data", o_rd_data, '0);
        rst = 1'b0;
        step();

        for (int e = 0; e < 8; e++) host_write(e, rand_vec());
        host_write(2, {LANES{16'h0005}});
        host_write(5, {LANES{16'h1234}});
        host_read(2);
        check_eq("entry2_bias", o_rd_data, {LANES{16'h0005}});

        run_job(2, 3, 1'b0, 1'b0, 1'b0);
        host_read(2);
        check_eq("entry2_accum3", o_rd_data, {LANES{16'h0008}});

        run_job(5, 0, 1'b0, 1'b0, 1'b0);
        host_read(5);
        check_eq("entry5_passthru", o_rd_data, {LANES{16'h1234}});

        run_job(3, 4, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("start_ignored_busy", W'(o_busy), W'(0));
        host_read(3);
        host_read(2);

        run_job(6, 2, 1'b0, 1'b0, 1'b1);
        host_read(6);

`ifdef NBOUT_FIRST_ZERO_EN
        run_job(4, 2, 1'b1, 1'b0, 1'b0);
        host_read(4);
        check_eq("first_zero", o_rd_data, {LANES{16'h0002}});
`endif

        // Same-cycle write and read to one address must return the old contents.
        newv      = rand_vec();
        i_wr_en   = 1'b1; i_wr_addr = 3'd7; i_wr_data = newv;
        i_rd_en   = 1'b1; i_rd_addr = 3'd7;
        step();
        i_wr_en = 1'b0; i_rd_en = 1'b0;
        check_eq("wr_rd_same_old", o_rd_data, model_mem[7]);
        model_mem[7] = newv;
        host_read(7);

        for (int j = 0; j < 24; j++) begin
            bit f;
            f = 1'b0;
`ifdef NBOUT_FIRST_ZERO_EN
            f = 1'($urandom_range(0, 1));
`endif
            run_job($urandom_range(0, 7), $urandom_range(0, 6), f, 1'b0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
        end
        step();
        for (int e = 0; e < 8; e++) host_read(e);

        // Reset in the middle of accumulation abandons the job without write-back.
        i_start = 1'b1; i_entry = 3'd1; i_num_accum = 8'd5;
`ifdef NBOUT_FIRST_ZERO_EN
        i_first = 1'b0;
`endif
        step();
        i_start = 1'b0;
        step();
        step();
        check_eq("mid_job_accum", W'(o_accum_en), W'(1));
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy", W'(o_busy), W'(0));
        check_eq("rst_mid_accum", W'(o_accum_en), W'(0));
        check_eq("rst_mid_psum", o_partial_sum, '0);
        check_eq("rst_mid_rd_data", o_rd_data, '0);
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        check_eq("rst_mid_no_done", W'(o_done), W'(0));
        host_read(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
